// File: rtl/vec_dot_engine.sv
// vec_dot_engine: streams two operand vectors from the vector memory,
// multiply-accumulates them, and writes the saturated 8-bit dot product
// back as two nibble writes (low nibble first).
// Latency: 3 cycles per element plus 2 write cycles; done rises 3n+2 edges
// after start is accepted (2 edges for n=0).
// Backpressure: none. The memory answers every read one cycle later, and
// start is only honoured in IDLE or DONE.
//
// Optional build macro: VEC_DOT_SIGNED_EN. When defined, elements, products
// and the accumulator are two's-complement and the result clips to -128..127.
// When undefined, everything is unsigned and the result clips to 0..255.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   start, len           run request and element count (clamped to MAX_LEN)
//   rd_en/rd_addr        memory read strobe/address; rd_data arrives a cycle later
//   wr_en/wr_addr/wr_data memory write strobe/address/data
//   busy, done, status   run progress (status: 0 idle, 1 running, 2 done)
//   result, sat          saturated dot product and saturation flag of last run
module vec_dot_engine #(
    parameter int WORD_BITS = 4,
    parameter int MAX_LEN   = 16,
    parameter int A_BASE    = 1,
    parameter int B_BASE    = 17,
    parameter int OUT_BASE  = 33,
    parameter int ACC_BITS  = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4:0]           len,
    output logic                 rd_en,
    output logic [5:0]           rd_addr,
    input  logic [WORD_BITS-1:0] rd_data,
    output logic                 wr_en,
    output logic [5:0]           wr_addr,
    output logic [WORD_BITS-1:0] wr_data,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           result,
    output logic                 sat,
    output logic [1:0]           status
);

    localparam int PROD_BITS = 2 * WORD_BITS;

    localparam logic [4:0] LP_MAX_LEN = 5'(MAX_LEN);
    localparam logic [5:0] LP_A_BASE  = 6'(A_BASE);
    localparam logic [5:0] LP_B_BASE  = 6'(B_BASE);
    localparam logic [5:0] LP_OUT_LO  = 6'(OUT_BASE);
    localparam logic [5:0] LP_OUT_HI  = 6'(OUT_BASE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_MAC,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [4:0]             r_n;
    logic [4:0]             r_i;
    logic [WORD_BITS-1:0]   r_a;
    logic [ACC_BITS-1:0]    r_acc;
    logic [7:0]             r_result;
    logic                   r_sat;

    logic [4:0]             w_len_clamp;
    logic [4:0]             w_i_inc;
    logic                   w_last;
    logic                   w_accept;
    logic [PROD_BITS-1:0]   w_prod;
    logic [ACC_BITS-1:0]    w_prod_ext;
    logic [ACC_BITS-1:0]    w_acc_next;
    logic                   w_fits;
    logic [7:0]             w_clip;

    assign w_len_clamp = (len > LP_MAX_LEN) ? LP_MAX_LEN : len;
    assign w_i_inc     = r_i + 5'd1;
    assign w_last      = (w_i_inc >= r_n);
    assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // In MAC, rd_data carries the B element requested during RD_B; the A
    // element was captured into r_a one cycle earlier.
`ifdef VEC_DOT_SIGNED_EN
    assign w_prod     = PROD_BITS'($signed(r_a) * $signed(rd_data));
    assign w_prod_ext = {{(ACC_BITS-PROD_BITS){w_prod[PROD_BITS-1]}}, w_prod};
    assign w_acc_next = r_acc + w_prod_ext;
    // Value fits in signed 8 bits when every bit from 7 upward equals the sign.
    assign w_fits     = (w_acc_next[ACC_BITS-1:7] == '0) ||
                        (w_acc_next[ACC_BITS-1:7] == '1);
    assign w_clip     = w_fits ? w_acc_next[7:0]
                               : (w_acc_next[ACC_BITS-1] ? 8'h80 : 8'h7F);
`else
    assign w_prod     = PROD_BITS'(r_a * rd_data);
    assign w_prod_ext = {{(ACC_BITS-PROD_BITS){1'b0}}, w_prod};
    assign w_acc_next = r_acc + w_prod_ext;
    // Value fits in unsigned 8 bits when no bit above bit 7 is set.
    assign w_fits     = (w_acc_next[ACC_BITS-1:8] == '0);
    assign w_clip     = w_fits ? w_acc_next[7:0] : 8'hFF;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and memory-side outputs, all decoded from the current state.
    always_comb begin
        w_state_next = r_state;
        rd_en        = 1'b0;
        rd_addr      = 6'd0;
        wr_en        = 1'b0;
        wr_addr      = 6'd0;
        wr_data      = '0;
        busy         = 1'b0;
        done         = 1'b0;
        status       = 2'd0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (r_state == S_DONE) begin
                    done   = 1'b1;
                    status = 2'd2;
                end
                if (w_accept) begin
                    w_state_next = (w_len_clamp == 5'd0) ? S_WR_LO : S_RD_A;
                end
            end
            S_RD_A: begin
                busy         = 1'b1;
                status       = 2'd1;
                rd_en        = 1'b1;
                rd_addr      = LP_A_BASE + {1'b0, r_i};
                w_state_next = S_RD_B;
            end
            S_RD_B: begin
                busy         = 1'b1;
                status       = 2'd1;
                rd_en        = 1'b1;
                rd_addr      = LP_B_BASE + {1'b0, r_i};
                w_state_next = S_MAC;
            end
            S_MAC: begin
                busy         = 1'b1;
                status       = 2'd1;
                w_state_next = w_last ? S_WR_LO : S_RD_A;
            end
            S_WR_LO: begin
                busy         = 1'b1;
                status       = 2'd1;
                wr_en        = 1'b1;
                wr_addr      = LP_OUT_LO;
                wr_data      = r_result[3:0];
                w_state_next = S_WR_HI;
            end
            S_WR_HI: begin
                busy         = 1'b1;
                status       = 2'd1;
                wr_en        = 1'b1;
                wr_addr      = LP_OUT_HI;
                wr_data      = r_result[7:4];
                w_state_next = S_DONE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n      <= 5'd0;
            r_i      <= 5'd0;
            r_a      <= '0;
            r_acc    <= '0;
            r_result <= 8'd0;
            r_sat    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        // Result clears too so an n=0 run writes zeros.
                        r_n      <= w_len_clamp;
                        r_i      <= 5'd0;
                        r_a      <= '0;
                        r_acc    <= '0;
                        r_result <= 8'd0;
                        r_sat    <= 1'b0;
                    end
                end
                S_RD_B: begin
                    r_a <= rd_data;
                end
                S_MAC: begin
                    r_acc <= w_acc_next;
                    r_i   <= w_i_inc;
                    if (w_last) begin
                        r_result <= w_clip;
                        r_sat    <= ~w_fits;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;
    assign sat    = r_sat;

endmodule
